// File: rtl/ex_div.sv
// Multi-cycle RV32M divider for the EX stage (DIV/DIVU/REM/REMU).
// Radix-2 restoring division, one quotient bit per cycle, with pipeline hold and flush.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic            accept;

  // Operand magnitudes and one restoring step; the partial remainder needs XLEN+1 bits
  // because an unsigned divisor can use the full width.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[XLEN-1];
    b_neg     = is_signed & divisor_i[XLEN-1];
    a_mag     = a_neg ? (~dividend_i + ONE) : dividend_i;
    b_mag     = b_neg ? (~divisor_i + ONE) : divisor_i;
    accept    = (state_q == ST_IDLE) & start_i & ~flush_i;

    trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    rem_step  = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    quo_step  = {quo_q[XLEN-2:0], ~trial[XLEN]};
    quo_fix   = neg_quo_q ? (~quo_step + ONE) : quo_step;
    rem_fix   = neg_rem_q ? (~rem_step + ONE) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_sel_d = op_i[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rd_d      = rd_addr_i;
          cnt_d     = '0;
          if (divisor_i == '0) begin
            result_d = op_i[1] ? dividend_i : ALL_ONES;
            state_d  = ST_DONE;
          end else if (is_signed && dividend_i == INT_MIN && divisor_i == ALL_ONES) begin
            result_d = op_i[1] ? '0 : INT_MIN;
            state_d  = ST_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          // The signed fix-up is registered on entry so result_o is stable through DONE.
          if (cnt_q == CNT_LAST) begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign hold_req_o = accept | (state_q == ST_CALC);
  assign done_o     = (state_q == ST_DONE) & ~flush_i;
  assign rd_we_o    = done_o;
  assign result_o   = result_q;
  assign rd_addr_o  = rd_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed plus randomised bench for ex_div; expected results come from a behavioural
// division model and are queued at issue, then popped when done_o pulses.
module tb_ex_div;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        hold_req_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbQueue[$];
  int   checks;
  int   errors;
  logic holdStart;

  ex_div #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .hold_req_o (hold_req_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .rd_we_o    (rd_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic logic [31:0] modelDiv(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic int modelLat(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; the start is taken on the following posedge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic keepStart);
    exp_t e;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    start_i    = 1'b1;
    holdStart  = keepStart;
    e.res      = modelDiv(op, a, b);
    e.rd       = rd;
    sbQueue.push_back(e);
    #1;
    check("hold_at_start", 32'(hold_req_o), 32'd1);
    @(posedge clk);
    #1;
    start_i = holdStart;
  endtask

  task automatic checkOutput(input string tag, input int expLat);
    int   cycles;
    int   holdBad;
    exp_t e;
    cycles  = 0;
    holdBad = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!done_o && hold_req_o !== 1'b1) holdBad++;
    end while (!done_o && cycles < 45);
    start_i = 1'b0;
    if (expLat > 0) check({tag, "_latency"}, 32'(cycles), 32'(expLat));
    check({tag, "_hold_while_busy"}, 32'(holdBad), 32'd0);
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
    end else begin
      e.res = 'x;
      e.rd  = 'x;
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_result"}, result_o, e.res);
    check({tag, "_rd_addr"}, 32'(rd_addr_o), 32'(e.rd));
    check({tag, "_rd_we"}, 32'(rd_we_o), 32'd1);
    check({tag, "_hold_in_done"}, 32'(hold_req_o), 32'd0);
    @(negedge clk);
    check({tag, "_single_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_idle_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks     = 0;
    errors     = 0;
    holdStart  = 1'b0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = 2'b00;
    dividend_i = '0;
    divisor_i  = '0;
    rd_addr_i  = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_hold", 32'(hold_req_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", 32'(rd_addr_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(2'b01, 32'd100, 32'd7, 5'd5, 1'b0);
    checkOutput("divu_100_7", 33);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    checkOutput("rem_m7_2", 33);
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    checkOutput("div_m7_2", 33);
    applyStimulus(2'b01, 32'd5, 32'd0, 5'd8, 1'b0);
    checkOutput("divu_by_zero", 1);
    applyStimulus(2'b11, 32'd5, 32'd0, 5'd9, 1'b0);
    checkOutput("remu_by_zero", 1);
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
    checkOutput("div_overflow", 1);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    checkOutput("rem_overflow", 0);
    applyStimulus(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    checkOutput("divu_min_max", 33);
    applyStimulus(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd13, 1'b0);
    checkOutput("div_100_m7", 33);
    applyStimulus(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd14, 1'b0);
    checkOutput("rem_m100_7", 33);
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 5'd15, 1'b0);
    checkOutput("remu_wide", 33);

    // Flush mid-calculation, then a fresh divide.
    op_i       = 2'b01;
    dividend_i = 32'd100;
    divisor_i  = 32'd3;
    rd_addr_i  = 5'd20;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_no_done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(busy_o), 32'd0);
    check("flush_idle_done", 32'(done_o), 32'd0);
    @(negedge clk);
    applyStimulus(2'b01, 32'd9, 32'd3, 5'd21, 1'b0);
    checkOutput("after_flush", 33);

    // Start together with flush in IDLE is rejected.
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("flush_start_hold", 32'(hold_req_o), 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_start_idle", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-operation.
    op_i       = 2'b01;
    dividend_i = 32'd1000;
    divisor_i  = 32'd7;
    rd_addr_i  = 5'd22;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_hold", 32'(hold_req_o), 32'd0);
    check("midreset_done", 32'(done_o), 32'd0);
    check("midreset_we", 32'(rd_we_o), 32'd0);
    check("midreset_result", result_o, 32'd0);
    check("midreset_rd", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start_i held high through CALC must not queue a second divide.
    applyStimulus(2'b01, 32'd1000, 32'd10, 5'd23, 1'b1);
    checkOutput("held_start", 33);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 28);
      applyStimulus(rop, ra, rb, 5'($urandom_range(1, 31)), 1'b0);
      checkOutput("random", modelLat(rop, ra, rb));
    end

    check("scoreboard_empty", 32'(sbQueue.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
